// File: rtl/bb_slave_mem.sv
// bb_slave_mem: parametrised Blackbone peripheral-bus slave memory.
// Width, depth and wait-state count are configurable; writes honour byte
// enables, completion is a one-cycle per_rdy pulse, and dropping per_en
// during the wait phase aborts the transfer.
// Optional feature macro: BB_SLAVE_MEM_ERR_EN. When defined, addresses at
// or beyond DEPTH complete with per_err=1, discard writes and read as 0.
// When undefined, such addresses wrap modulo DEPTH and per_err stays 0.
module bb_slave_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    mclk,
  input  logic                    mrst,
  input  logic [ADDR_WIDTH-1:0]   per_addr,
  input  logic                    per_en,
  input  logic                    per_we,
  input  logic [DATA_WIDTH/8-1:0] per_be,
  input  logic [DATA_WIDTH-1:0]   per_dout,
  output logic [DATA_WIDTH-1:0]   per_din,
  output logic                    per_rdy,
  output logic                    per_err
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t state, state_nxt;
  logic   capture;
  logic   enter_ack;
  logic   [3:0] wcnt;

  // request captured at the start of a transfer
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic                  we_p0;
  logic [BE_W-1:0]       be_p0;
  logic [DATA_WIDTH-1:0] dout_p0;

  // live request: the bus inputs on the capture edge, the captured copy afterwards
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_we;
  logic [BE_W-1:0]       req_be;
  logic [DATA_WIDTH-1:0] req_dout;
  logic [IDX_W-1:0]      req_idx;
  logic                  req_ok;
  logic                  wr_commit;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] mem_rd [DEPTH];

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'({1'b0, a} % DEPTH_A);
  endfunction

  assign req_addr = capture ? per_addr : addr_p0;
  assign req_we   = capture ? per_we   : we_p0;
  assign req_be   = capture ? per_be   : be_p0;
  assign req_dout = capture ? per_dout : dout_p0;
  assign req_idx  = word_idx(req_addr);

`ifdef BB_SLAVE_MEM_ERR_EN
  assign req_ok = ({1'b0, req_addr} < DEPTH_A);
`else
  assign req_ok = 1'b1;
`endif

  // the write lands on the same edge that moves the FSM into ACK
  assign wr_commit = enter_ack && req_we && req_ok;

  // FSM state register
  always_ff @(posedge mclk) begin
    if (!mrst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next-state logic; an abort (per_en low in WAIT) wins over the counter expiring
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    enter_ack = 1'b0;
    case (state)
      S_IDLE: begin
        if (per_en) begin
          capture = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nxt = S_ACK;
            enter_ack = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!per_en) begin
          state_nxt = S_IDLE;
        end else if (wcnt == 4'd0) begin
          state_nxt = S_ACK;
          enter_ack = 1'b1;
        end
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // wait-state counter, loaded on capture and counted down while waiting
  always_ff @(posedge mclk) begin
    if (!mrst)                             wcnt <= 4'd0;
    else if (capture)                      wcnt <= WS_LOAD;
    else if (state == S_WAIT && wcnt != 4'd0) wcnt <= wcnt - 4'd1;
  end

  // request capture; later bus changes are ignored until the next transfer
  always_ff @(posedge mclk) begin
    if (capture) begin
      addr_p0 <= per_addr;
      we_p0   <= per_we;
      be_p0   <= per_be;
      dout_p0 <= per_dout;
    end
  end

  // byte-lane merge of the write data into the addressed word
  always_comb begin
    wr_word = mem_rd[req_idx];
    for (int b = 0; b < BE_W; b++) begin
      if (req_be[b]) wr_word[8*b +: 8] = req_dout[8*b +: 8];
    end
  end

  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    logic [DATA_WIDTH-1:0] word_q;

    // one storage word; reset restores its own index as contents
    always_ff @(posedge mclk) begin
      if (!mrst)                                      word_q <= DATA_WIDTH'(w);
      else if (wr_commit && (req_idx == IDX_W'(w)))  word_q <= wr_word;
    end

    assign mem_rd[w] = word_q;
  end

  // response stage: per_din is nonzero only alongside per_rdy on a good read
  always_ff @(posedge mclk) begin
    if (!mrst) begin
      per_rdy <= 1'b0;
      per_din <= '0;
      per_err <= 1'b0;
    end else begin
      per_rdy <= (state == S_ACK);
      per_din <= '0;
      per_err <= 1'b0;
      if (state == S_ACK) begin
        if (!req_ok)      per_err <= 1'b1;
        else if (!req_we) per_din <= mem_rd[req_idx];
      end
    end
  end

endmodule

// File: tb/tb_bb_slave_mem.sv
// Scoreboard bench for bb_slave_mem: two instances (WAIT_STATES=0/DEPTH=256
// and WAIT_STATES=3/DEPTH=128) driven by directed and random transfers.
module tb_bb_slave_mem;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int D0 = 256;
  localparam int W0 = 0;
  localparam int D1 = 128;
  localparam int W1 = 3;

  logic mclk = 1'b0;
  logic mrst = 1'b0;
  always #5 mclk = ~mclk;

  logic [AW-1:0] addr [2];
  logic          en   [2];
  logic          we   [2];
  logic [3:0]    be   [2];
  logic [DW-1:0] dout [2];
  logic [DW-1:0] din  [2];
  logic          rdy  [2];
  logic          err  [2];

  bb_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D0), .WAIT_STATES(W0)) u_dut0 (
    .mclk(mclk), .mrst(mrst), .per_addr(addr[0]), .per_en(en[0]), .per_we(we[0]),
    .per_be(be[0]), .per_dout(dout[0]), .per_din(din[0]), .per_rdy(rdy[0]), .per_err(err[0])
  );

  bb_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D1), .WAIT_STATES(W1)) u_dut1 (
    .mclk(mclk), .mrst(mrst), .per_addr(addr[1]), .per_en(en[1]), .per_we(we[1]),
    .per_be(be[1]), .per_dout(dout[1]), .per_din(din[1]), .per_rdy(rdy[1]), .per_err(err[1])
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          e;
    longint        due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int            depth_of [2] = '{D0, D1};
  int            ws_of    [2] = '{W0, W1};
  logic [DW-1:0] model [2][256];
  longint        cyc = 0;
  int            total = 0;
  int            bad = 0;
  bit            mon_on = 1'b0;

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic check(input string nm, input int i, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s[u%0d] @cyc %0d got=%0h want=%0h", nm, i, cyc, act, want);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push_exp(input int i, input exp_t e);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 256; a++) model[i][a] = DW'(a);
    q0.delete();
    q1.delete();
  endtask

  // reference behaviour: wrap or error on range, byte-lane writes, reads return stored word
  function automatic exp_t predict(input int i, input logic w, input logic [AW-1:0] a,
                                   input logic [3:0] b, input logic [DW-1:0] d);
    exp_t e;
    int   idx;
    e.data = '0;
    e.e    = 1'b0;
    e.due  = 0;
`ifdef BB_SLAVE_MEM_ERR_EN
    if (int'(a) >= depth_of[i]) begin
      e.e = 1'b1;
      return e;
    end
    idx = int'(a);
`else
    idx = int'(a) % depth_of[i];
`endif
    if (w) begin
      for (int k = 0; k < 4; k++)
        if (b[k]) model[i][idx][8*k +: 8] = d[8*k +: 8];
    end else begin
      e.data = model[i][idx];
    end
    return e;
  endfunction

  // complete transfer; call at a negedge with the instance idle
  task automatic xfer(input int i, input logic w, input logic [AW-1:0] a,
                      input logic [3:0] b, input logic [DW-1:0] d);
    exp_t e;
    e = predict(i, w, a, b, d);
    e.due = cyc + ws_of[i] + 2;
    push_exp(i, e);
    addr[i] = a; we[i] = w; be[i] = b; dout[i] = d; en[i] = 1'b1;
    @(negedge mclk);
    addr[i] = AW'($urandom); we[i] = 1'($urandom); be[i] = 4'($urandom); dout[i] = $urandom;
    repeat (ws_of[i]) @(negedge mclk);
    en[i] = 1'b0;
    @(negedge mclk);
  endtask

  // transfer abandoned after n wait cycles (n < WAIT_STATES); no response expected
  task automatic abort_xfer(input int i, input logic w, input logic [AW-1:0] a,
                            input logic [3:0] b, input logic [DW-1:0] d, input int n);
    addr[i] = a; we[i] = w; be[i] = b; dout[i] = d; en[i] = 1'b1;
    @(negedge mclk);
    repeat (n) @(negedge mclk);
    en[i] = 1'b0;
    @(negedge mclk);
  endtask

  task automatic mon_step(input int i);
    exp_t e;
    if (!rdy[i]) begin
      check("idle_din", i, 64'(din[i]), 64'd0);
      check("idle_err", i, 64'(err[i]), 64'd0);
      if (qsize(i) > 0) begin
        e = (i == 0) ? q0[0] : q1[0];
        if (e.due < cyc) begin
          check("late_rdy", i, 64'(rdy[i]), 64'd1);
          if (i == 0) void'(q0.pop_front());
          else        void'(q1.pop_front());
        end
      end
    end else begin
      check("pending_on_rdy", i, 64'(qsize(i) > 0), 64'd1);
      if (qsize(i) > 0) begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        check("rdy_cycle", i, 64'(cyc), 64'(e.due));
        check("din", i, 64'(din[i]), 64'(e.data));
        check("err", i, 64'(err[i]), 64'(e.e));
      end
    end
  endtask

  // monitor: compares every DUT response against the scoreboard queues
  always @(negedge mclk) begin
    if (mon_on) begin
      mon_step(0);
      mon_step(1);
    end
  end

  task automatic rand_stream(input int i, input int n);
    logic [AW-1:0] a;
    logic          w;
    for (int t = 0; t < n; t++) begin
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(16, 19)) : AW'($urandom);
      w = 1'($urandom);
      if (ws_of[i] > 0 && $urandom_range(0, 5) == 0) begin
        abort_xfer(i, w, a, 4'($urandom), $urandom, $urandom_range(0, ws_of[i] - 1));
      end else begin
        xfer(i, w, a, 4'($urandom), $urandom);
        if (w && $urandom_range(0, 2) == 0) xfer(i, 1'b0, a, 4'($urandom), $urandom);
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge mclk);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; en[i] = 1'b0; we[i] = 1'b0; be[i] = '0; dout[i] = '0;
    end
    mrst = 1'b0;
    repeat (3) @(negedge mclk);
    for (int i = 0; i < 2; i++) begin
      check("rst_rdy", i, 64'(rdy[i]), 64'd0);
      check("rst_din", i, 64'(din[i]), 64'd0);
      check("rst_err", i, 64'(err[i]), 64'd0);
    end
    model_reset();
    mrst = 1'b1;
    @(negedge mclk);
    mon_on = 1'b1;

    // reset contents and byte-enable merge, zero wait states
    xfer(0, 1'b0, 8'h05, 4'h0, 32'h0);
    xfer(0, 1'b1, 8'h10, 4'b0101, 32'hDEADBEEF);
    xfer(0, 1'b0, 8'h10, 4'hF, 32'h0);
    xfer(0, 1'b1, 8'h11, 4'b0000, 32'hFFFFFFFF);
    xfer(0, 1'b0, 8'h11, 4'h0, 32'h0);

    // three wait states: full write/readback and an abort
    xfer(1, 1'b1, 8'h20, 4'hF, 32'h12345678);
    xfer(1, 1'b0, 8'h20, 4'h0, 32'h0);
    abort_xfer(1, 1'b1, 8'h30, 4'hF, 32'hFFFFFFFF, 1);
    xfer(1, 1'b0, 8'h30, 4'h0, 32'h0);

    // out-of-range address on the 128-deep instance
    xfer(1, 1'b0, 8'h90, 4'h0, 32'h0);
    xfer(1, 1'b1, 8'h90, 4'hF, 32'hCAFEF00D);
    xfer(1, 1'b0, 8'h10, 4'h0, 32'h0);

    // reset in the middle of a read's wait phase
    xfer(1, 1'b1, 8'h40, 4'hF, 32'hAAAA5555);
    addr[1] = 8'h40; we[1] = 1'b0; be[1] = 4'h0; en[1] = 1'b1;
    @(negedge mclk);
    mrst = 1'b0; en[1] = 1'b0;
    @(negedge mclk);
    for (int i = 0; i < 2; i++) begin
      check("midrst_rdy", i, 64'(rdy[i]), 64'd0);
      check("midrst_din", i, 64'(din[i]), 64'd0);
      check("midrst_err", i, 64'(err[i]), 64'd0);
    end
    model_reset();
    mrst = 1'b1;
    @(negedge mclk);
    xfer(1, 1'b0, 8'h40, 4'h0, 32'h0);

    // randomized traffic on both instances concurrently
    fork
      rand_stream(0, 80);
      rand_stream(1, 80);
    join

    for (int t = 0; t < 50 && (q0.size() > 0 || q1.size() > 0); t++) @(negedge mclk);
    repeat (2) @(negedge mclk);
    check("drain", 0, 64'(q0.size()), 64'd0);
    check("drain", 1, 64'(q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bb_slave_mem.md
Name: bb_slave_mem

Overview:
Parametrised peripheral-bus slave memory model for the Blackbone bus UVM environment. Its width, depth and wait-state count are configurable, and it adds byte-enable writes, a ready handshake and transfer abort. It sits on the slave side of the bus, is driven by the master agent, and backs the scoreboard's reference memory.

Parameters:
DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8.
ADDR_WIDTH, 8, word address width in bits.
DEPTH, 256, number of words; must satisfy DEPTH <= 2**ADDR_WIDTH.
WAIT_STATES, 0, extra cycles before ready; range 0..15.

Ports:
mclk  input  1  clock; all logic on the rising edge.
mrst  input  1  reset; synchronous, active-low.
per_addr  input  ADDR_WIDTH  word address.
per_en  input  1  transfer request.
per_we  input  1  1 = write, 0 = read.
per_be  input  DATA_WIDTH/8  byte enables for writes; bit i covers byte lane i.
per_dout  input  DATA_WIDTH  write data, master to slave.
per_din  output  DATA_WIDTH  read data, slave to master.
per_rdy  output  1  transfer complete; one-cycle pulse.
per_err  output  1  error; only meaningful with the optional feature.

Behaviour:
- Reset (mrst=0 at a rising edge):
  - state=IDLE, wait counter=0, per_din=0, per_rdy=0, per_err=0.
  - mem[i] = i, truncated to DATA_WIDTH, for i in 0..DEPTH-1.
  - Reset in any state abandons the transfer in progress with no memory update.
- FSM states IDLE, WAIT, ACK:
  - IDLE, per_en=1: capture addr, we, be, dout.
    - If WAIT_STATES=0, go to ACK.
    - Otherwise load counter=WAIT_STATES-1 and go to WAIT.
  - WAIT, per_en=0: abort. Go to IDLE; no write, per_rdy stays 0.
  - WAIT, counter=0: go to ACK. Otherwise decrement the counter.
  - ACK: per_rdy=1 for exactly one cycle, then go to IDLE.
- Latency:
  - per_rdy rises WAIT_STATES+1 cycles after the edge at which per_en was first sampled high in IDLE.
  - Minimum cadence is one transfer per WAIT_STATES+2 cycles. If per_en is still high in IDLE after ACK, that is a new transfer.
- Write:
  - Committed at the edge that enters ACK.
  - Byte lane i of mem[addr] takes per_dout lane i only if per_be[i]=1.
  - per_be=0 completes normally with no memory change.
- Read:
  - per_din = mem[addr] is registered together with per_rdy, i.e. valid only while per_rdy=1; per_din=0 in every other cycle.
  - A read at the same address as the immediately preceding write returns the new data.
  - per_be is ignored on reads.
- Captured request: changes to per_addr, per_we, per_be or per_dout after capture are ignored.
- Address range: addresses >= DEPTH are handled per the optional feature.

Optional Feature:
Macro: BB_SLAVE_MEM_ERR_EN
- Defined:
  - An address >= DEPTH completes with per_rdy=1 and per_err=1 in the same cycle.
  - Writes to such an address are discarded; reads return per_din=0.
  - per_err=0 at all other times.
- Undefined:
  - The address wraps to addr mod DEPTH.
  - per_err is tied to 0.

Test Plan:
1. Reset, then read addr 0x05 (WAIT_STATES=0) -> per_rdy one edge after request with per_din=0x00000005; per_din=0 in all other cycles.
2. Write 0xDEADBEEF to 0x10 with per_be=0b0101, then read 0x10 -> returns 0x00AD00EF (original 0x00000010 with lanes 0 and 2 replaced).
3. WAIT_STATES=3: write 0x12345678 to 0x20 with per_be=0xF, then read it back -> each per_rdy occurs 4 cycles after request; readback equals 0x12345678.
4. WAIT_STATES=3: write 0xFFFFFFFF to 0x30, drop per_en after 1 cycle in WAIT -> no per_rdy; a later read of 0x30 returns 0x00000030.
5. DEPTH=128: access 0x90 -> with BB_SLAVE_MEM_ERR_EN, per_rdy=1 and per_err=1 and the read returns 0. Without the macro, the read returns mem[0x10]=0x00000010 and per_err=0.
6. Write 0xAAAA5555 to 0x40, then assert mrst=0 in the following cycle during a read of 0x40 in WAIT -> all outputs 0 on the next edge, no per_rdy; after release, a read of 0x40 returns 0x00000040.
